// File: rtl/pc_pkg.sv
// Shared fetch-path definitions used by the sequencer, jump lookup table and imem.
package pc_pkg;

    // Default PC width; all PC arithmetic wraps modulo 2**PC_D_DEF.
    localparam int unsigned PC_D_DEF     = 12;
    // PC value loaded on every start pulse.
    localparam int unsigned START_PC_DEF = 0;
    // Default width of the retired-fetch counter.
    localparam int unsigned CNT_W_DEF    = 16;
    // Jump lookup table index width.
    localparam int unsigned LUT_AW       = 8;

    // Run/halt state of the fetch sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage : pc_pkg

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer: advance, hold, or load a jump
// target from the external combinational lookup table; owns run/halt state and
// a saturating retired-fetch counter.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned D        = PC_D_DEF,
    parameter int unsigned START_PC = START_PC_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [LUT_AW-1:0] jump_idx,
    input  logic              halt_req,
    input  logic [D-1:0]      lut_target,
    output logic [LUT_AW-1:0] lut_addr,
    output logic [D-1:0]      prog_ctr,
    output logic              flush,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [D-1:0]     START_PC_V = D'(START_PC);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    fetch_state_t     state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, halted_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [D-1:0]     pc_inc;

    // Lookup table is addressed straight from the decoder, in every state.
    assign lut_addr = jump_idx;

    // Saturating count and wrapping PC increment.
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        pc_inc  = pc_q + D'(1);
    end

    // Next-state and datapath selection, priority start > halt > stall > jump > advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC_V;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (start) begin
                    pc_d  = START_PC_V;
                    cnt_d = '0;
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (stall) begin
                    // Hold; any concurrent jump is re-presented by the decoder later.
                    pc_d = pc_q;
                end else if (jump_en) begin
                    pc_d    = lut_target;
                    flush_d = 1'b1;
                    cnt_d   = cnt_inc;
                end else begin
                    pc_d  = pc_inc;
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC, flush and counter registers; status flags registered from next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            flush_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d == RUN);
            halted_q <= (state_d == HALT);
        end
    end

    assign prog_ctr  = pc_q;
    assign flush     = flush_q;
    assign fetch_cnt = cnt_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule : pc_fetch_ctrl

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: cycle-level reference model plus directed literal checks.
module tb_pc_fetch_ctrl;

    localparam int unsigned D     = 12;
    localparam int unsigned CNT_W = 4;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          stall;
    logic          jump_en;
    logic [7:0]    jump_idx;
    logic          halt_req;
    logic [D-1:0]  lut_target;
    logic [7:0]    lut_addr;
    logic [D-1:0]  prog_ctr;
    logic          flush;
    logic          busy;
    logic          halted;
    logic [CNT_W-1:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state: mode 0 idle, 1 running, 2 halted.
    int           m_mode;
    logic [D-1:0] m_pc;
    int           m_cnt;
    bit           m_flush;

    pc_fetch_ctrl #(
        .D(D),
        .START_PC(0),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .stall(stall),
        .jump_en(jump_en),
        .jump_idx(jump_idx),
        .halt_req(halt_req),
        .lut_target(lut_target),
        .lut_addr(lut_addr),
        .prog_ctr(prog_ctr),
        .flush(flush),
        .busy(busy),
        .halted(halted),
        .fetch_cnt(fetch_cnt)
    );

    // Jump lookup table contents.
    function automatic logic [D-1:0] lut_fn(input logic [7:0] idx);
        case (idx)
            8'd2:    return 12'd10;
            8'd3:    return 12'd137;
            8'd7:    return 12'd0;
            default: return {idx, 4'hF};
        endcase
    endfunction

    assign lut_target = lut_fn(lut_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the fetch rules.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode  = 0;
            m_pc    = '0;
            m_cnt   = 0;
            m_flush = 1'b0;
        end else begin
            m_flush = 1'b0;
            if (start) begin
                m_mode = 1;
                m_pc   = '0;
                m_cnt  = 0;
            end else if (m_mode == 1) begin
                if (halt_req) begin
                    m_mode = 2;
                end else if (!stall) begin
                    if (jump_en) begin
                        m_pc    = lut_fn(jump_idx);
                        m_flush = 1'b1;
                    end else begin
                        m_pc = D'((int'(m_pc) + 1) % 4096);
                    end
                    if (m_cnt < 15) m_cnt++;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_prog_ctr",  32'(prog_ctr),  32'(m_pc));
            chk("m_flush",     32'(flush),     32'(m_flush));
            chk("m_busy",      32'(busy),      32'(m_mode == 1));
            chk("m_halted",    32'(halted),    32'(m_mode == 2));
            chk("m_fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
            chk("m_lut_addr",  32'(lut_addr),  32'(jump_idx));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        stall    = 1'b0;
        jump_en  = 1'b0;
        jump_idx = 8'd0;
        halt_req = 1'b0;
        repeat (2) cyc();
        chk("rst_pc", 32'(prog_ctr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        cyc();
        chk("idle_pc", 32'(prog_ctr), 32'd0);

        // T2: start then five free-running cycles.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_pc", 32'(prog_ctr), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        repeat (5) cyc();
        chk("t2_pc", 32'(prog_ctr), 32'd5);
        chk("t2_cnt", 32'(fetch_cnt), 32'd5);
        chk("t2_flush", 32'(flush), 32'd0);

        // T3: jump through table index 3.
        jump_en  = 1'b1;
        jump_idx = 8'd3;
        #1;
        chk("t3_lut_addr", 32'(lut_addr), 32'd3);
        cyc();
        jump_en = 1'b0;
        chk("t3_pc", 32'(prog_ctr), 32'd137);
        chk("t3_flush", 32'(flush), 32'd1);
        chk("t3_cnt", 32'(fetch_cnt), 32'd6);
        cyc();
        chk("t3_pc_next", 32'(prog_ctr), 32'd138);
        chk("t3_flush_next", 32'(flush), 32'd0);

        // T6 plus back-to-back jumps: to 0, then to 4095, then wrap to 0.
        jump_en  = 1'b1;
        jump_idx = 8'd7;
        cyc();
        chk("t6_pc", 32'(prog_ctr), 32'd0);
        chk("t6_flush", 32'(flush), 32'd1);
        jump_idx = 8'd255;
        cyc();
        jump_en = 1'b0;
        chk("b2b_pc", 32'(prog_ctr), 32'd4095);
        chk("b2b_flush", 32'(flush), 32'd1);
        cyc();
        chk("wrap_pc", 32'(prog_ctr), 32'd0);
        chk("wrap_flush", 32'(flush), 32'd0);

        // T5: counter saturates at 15.
        repeat (20) cyc();
        chk("sat_cnt", 32'(fetch_cnt), 32'd15);
        chk("sat_pc", 32'(prog_ctr), 32'd20);

        // T4: jump to 10, then jump+stall holds, then halt beats jump.
        jump_en  = 1'b1;
        jump_idx = 8'd2;
        cyc();
        chk("t4_pc10", 32'(prog_ctr), 32'd10);
        stall    = 1'b1;
        jump_idx = 8'd3;
        cyc();
        stall = 1'b0;
        chk("t4_stall_pc", 32'(prog_ctr), 32'd10);
        chk("t4_stall_flush", 32'(flush), 32'd0);
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        chk("t4_halt_pc", 32'(prog_ctr), 32'd10);
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        cyc();
        jump_en = 1'b0;
        chk("halt_jump_pc", 32'(prog_ctr), 32'd10);
        chk("halt_jump_flush", 32'(flush), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_pc", 32'(prog_ctr), 32'd0);
        chk("restart_cnt", 32'(fetch_cnt), 32'd0);
        chk("restart_halted", 32'(halted), 32'd0);

        // Start while running outranks a jump.
        repeat (3) cyc();
        start   = 1'b1;
        jump_en = 1'b1;
        cyc();
        start   = 1'b0;
        jump_en = 1'b0;
        chk("run_restart_pc", 32'(prog_ctr), 32'd0);
        chk("run_restart_flush", 32'(flush), 32'd0);

        // T1: async reset mid-RUN at PC 37 with a jump pending.
        repeat (37) cyc();
        chk("t1_pc37", 32'(prog_ctr), 32'd37);
        jump_en  = 1'b1;
        jump_idx = 8'd3;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_pc", 32'(prog_ctr), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_cnt", 32'(fetch_cnt), 32'd0);
        chk("t1_flush", 32'(flush), 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("idle_jump_pc", 32'(prog_ctr), 32'd0);
        chk("idle_jump_busy", 32'(busy), 32'd0);
        chk("idle_jump_flush", 32'(flush), 32'd0);
        jump_en = 1'b0;
        cyc();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_fetch_ctrl
